mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequential front/back-end for the 31-input, 2-bit channel multiplexer. It arbitrates round-robin among 31 per-channel requests and drives the multiplexer's 5-bit select. It then samples the multiplexer's 2-bit output and presents it, tagged with its channel number, on a valid/ready output port. Each request is acknowledged with a one-cycle pulse when its data is consumed.

## Interface
- NUM_CH, 31, number of channels; legal select values 0..NUM_CH-1
- SEL_W, 5, select/channel-number width
- DATA_W, 2, data width of the multiplexer output

- clk  input  1  single clock, all state rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- ch_req  input  NUM_CH  per-channel request, level, bit i = channel i
- ch_ack  output  NUM_CH  one-hot pulse, one cycle, on the handshake cycle of channel i's transfer
- sel  output  SEL_W  registered select to the multiplexer
- mux_out  input  DATA_W  multiplexer output, combinational function of sel
- o_valid  output  1  output data valid
- o_ready  input  1  consumer ready
- o_ch  output  SEL_W  channel number of o_data
- o_data  output  DATA_W  captured multiplexer data
- busy  output  1  high in any state other than IDLE
- o_par  output  1  even parity of o_data; present only with MUX_SCAN_PARITY_EN

## Operation
- Reset values: sel=0, o_valid=0, o_ch=0, o_data=0, ch_ack=0, busy=0, o_par=0, state=IDLE, rr pointer=0.
- FSM states: IDLE, SEL, CAP, OUT.
- IDLE: if any ch_req bit is set, grant = first set bit searching upward from the rr pointer, wrapping 30->0. Register sel=grant and go to SEL. Otherwise stay; sel holds its last value.
- SEL: sel is stable for the whole cycle. At the clock edge, o_data<=mux_out, o_ch<=sel, o_valid<=1, go to OUT. CAP is a one-cycle alias of SEL, reserved for settle; with no settle configured, SEL proceeds straight to OUT.
- OUT: o_valid, o_ch and o_data hold stable until o_valid && o_ready.
- OUT handshake cycle:
  - ch_ack[o_ch] pulses for this cycle.
  - rr pointer <= (o_ch+1) mod 31.
  - Arbitration runs in the same cycle over ch_req with bit o_ch masked.
  - If a grant exists: sel<=grant, o_valid<=0, go to SEL.
  - If not: o_valid<=0, go to IDLE.
- Requesters drop ch_req[i] no later than the cycle after ch_ack[i]. A re-request is honoured from the following arbitration.
- ch_req changes while not in IDLE or the OUT handshake cycle are ignored.
- sel never takes value 31.
- mux_out is sampled only at the end of SEL.
- ch_req bits above NUM_CH-1 do not exist. The rr pointer computes modulo NUM_CH, never reaching 31.

## Timing
- Request to o_valid: request seen in IDLE cycle N; sel valid in cycle N+1; o_valid high in cycle N+2.
- Sustained throughput with o_ready tied high and multiple requesters: one transfer per 2 cycles (OUT, SEL alternating).
- o_ready low holds OUT indefinitely. Outputs must not change, and ch_ack stays 0.
- o_ready may be high before o_valid; it has no effect outside OUT.
- Asynchronous reset mid-transfer: the transfer is dropped with no ch_ack, all outputs go immediately to their reset values, and the rr pointer goes to 0. The first post-reset arbitration favours channel 0.
- All outputs are registered except ch_ack, which is decoded from state, o_ready and o_ch (a registered-input path).

## Configuration
- MUX_SCAN_PARITY_EN defined: o_par exists and is registered with o_data, o_par = ^o_data, reset 0.
- MUX_SCAN_PARITY_EN undefined: o_par port and logic are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst_n=0 mid-OUT with o_valid=1 -> same-cycle o_valid=0, sel=0, busy=0, and no ch_ack.
- Single request: ch_req=1<<5, mux_out=2'b10 when sel=5, o_ready=1 -> o_valid two cycles after the request, o_ch=5, o_data=2'b10, ch_ack=1<<5 for one cycle.
- Round-robin wrap: ch_req bits 0, 29 and 30 held, o_ready=1, pointer initially 29 -> o_ch sequence 29, 30, 0, 29, one transfer every 2 cycles.
- Backpressure: o_ready=0 for 10 cycles while o_valid=1 -> o_ch and o_data stable, ch_ack=0 throughout. Then o_ready=1 for one cycle -> single ack.
- Idle select hold: with no requests after a transfer from channel 12 -> sel stays 12 and busy=0.
- Parity (MUX_SCAN_PARITY_EN): o_data=2'b11 -> o_par=0; o_data=2'b01 -> o_par=1.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - request/select/output bundle for mux_scan_ctrl (o_par only with MUX_SCAN_PARITY_EN)
interface mux_scan_ctrl_if #(
  parameter int NUM_CH = 31,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2
);
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_ack;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] mux_out;
  logic              o_valid;
  logic              o_ready;
  logic [SEL_W-1:0]  o_ch;
  logic [DATA_W-1:0] o_data;
`ifdef MUX_SCAN_PARITY_EN
  logic              o_par;
`endif

  modport master (
    input  ch_req, mux_out, o_ready,
`ifdef MUX_SCAN_PARITY_EN
    output o_par,
`endif
    output ch_ack, sel, o_valid, o_ch, o_data
  );

  modport slave (
    output ch_req, mux_out, o_ready,
`ifdef MUX_SCAN_PARITY_EN
    input  o_par,
`endif
    input  ch_ack, sel, o_valid, o_ch, o_data
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - round-robin scan controller for a 31:1 2-bit mux; MUX_SCAN_PARITY_EN adds o_par
module mux_scan_ctrl #(
  parameter int NUM_CH = 31,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.master  bus,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SEL, CAP, OUT} state_t;

  state_t            state, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d, ptr_nxt, pick_ptr;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [NUM_CH-1:0] req_mask;
  logic [NUM_CH-1:0] ack;
  logic [SEL_W:0]    pick;
  logic              xfer;

  // First requesting channel at or above ptr, wrapping NUM_CH-1 -> 0; {found, channel}
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [SEL_W-1:0]  ptr);
    logic             found;
    logic [SEL_W-1:0] g;
    logic [SEL_W:0]   idx6;
    logic [SEL_W-1:0] idx;
    found = 1'b0;
    g     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx6 = {1'b0, ptr} + (SEL_W+1)'(i);
      if (idx6 >= (SEL_W+1)'(NUM_CH)) idx6 = idx6 - (SEL_W+1)'(NUM_CH);
      idx = idx6[SEL_W-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    return {found, g};
  endfunction

  assign xfer    = (state == OUT) && valid_q && bus.o_ready;
  assign ptr_nxt = (ch_q == SEL_W'(NUM_CH-1)) ? '0 : ch_q + SEL_W'(1);

  // The channel being acknowledged is masked so a lingering request cannot win again at once
  always_comb begin
    req_mask = bus.ch_req;
    pick_ptr = ptr_q;
    if (state == OUT) begin
      req_mask[ch_q] = 1'b0;
      pick_ptr       = ptr_nxt;
    end
    pick = rr_pick(req_mask, pick_ptr);
  end

  always_comb begin
    ack = '0;
    if (xfer) ack[ch_q] = 1'b1;
  end

  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state)
      IDLE: begin
        if (pick[SEL_W]) begin
          sel_d   = pick[SEL_W-1:0];
          state_d = SEL;
        end
      end
      SEL, CAP: begin
        data_d  = bus.mux_out;
        ch_d    = sel_q;
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (xfer) begin
          ptr_d   = ptr_nxt;
          valid_d = 1'b0;
          if (pick[SEL_W]) begin
            sel_d   = pick[SEL_W-1:0];
            state_d = SEL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_q   <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      sel_q   <= sel_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^data_d;
  end

  assign bus.o_par = par_q;
`endif

  assign bus.sel     = sel_q;
  assign bus.o_ch    = ch_q;
  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.ch_ack  = ack;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - directed self-checking bench for mux_scan_ctrl
module tb_mux_scan_ctrl;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_chk;
  int   n_err;

  mux_scan_ctrl_if bus ();

  // Mux model: data for channel c is the inverted low two bits of c
  assign bus.mux_out = ~bus.sel[1:0];

  mux_scan_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [30:0] bit_of(input int ch);
    logic [30:0] one;
    one = 31'd1;
    return one << ch;
  endfunction

  function automatic logic [1:0] exp_data(input int ch);
    return ~2'(ch);
  endfunction

  task automatic do_xfer(input int ch);
    bus.ch_req  = bit_of(ch);
    bus.o_ready = 1'b1;
    tick();
    chk("xfer_sel", 32'(bus.sel), 32'(ch));
    chk("xfer_sel_valid", 32'(bus.o_valid), 32'd0);
    tick();
    chk("xfer_valid", 32'(bus.o_valid), 32'd1);
    chk("xfer_ch", 32'(bus.o_ch), 32'(ch));
    chk("xfer_data", 32'(bus.o_data), 32'(exp_data(ch)));
    chk("xfer_ack", 32'(bus.ch_ack), 32'(bit_of(ch)));
    bus.ch_req = '0;
    tick();
    chk("xfer_done_valid", 32'(bus.o_valid), 32'd0);
    chk("xfer_done_ack", 32'(bus.ch_ack), 32'd0);
    chk("xfer_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int rr_seq[4];
    n_chk = 0;
    n_err = 0;
    rr_seq = '{29, 30, 0, 29};
    rst_n = 1'b0;
    bus.ch_req  = '0;
    bus.o_ready = 1'b0;
    #1;
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_ch", 32'(bus.o_ch), 32'd0);
    chk("rst_data", 32'(bus.o_data), 32'd0);
    chk("rst_ack", 32'(bus.ch_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_par", 32'(bus.o_par), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Single request on channel 5; pointer ends at 6
    do_xfer(5);

    // Reset while holding OUT on channel 9
    bus.ch_req  = bit_of(9);
    bus.o_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
    chk("pre_rst_ch", 32'(bus.o_ch), 32'd9);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.o_valid), 32'd0);
    chk("mid_rst_sel", 32'(bus.sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ack", 32'(bus.ch_ack), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.ch_req  = bit_of(9) | bit_of(0);
    bus.o_ready = 1'b1;
    tick();
    tick();
    chk("post_rst_ch", 32'(bus.o_ch), 32'd0);
    chk("post_rst_ack", 32'(bus.ch_ack), 32'(bit_of(0)));
    bus.ch_req = '0;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Backpressure on channel 7
    bus.ch_req  = bit_of(7);
    bus.o_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(bus.o_valid), 32'd1);
      chk("bp_ch", 32'(bus.o_ch), 32'd7);
      chk("bp_data", 32'(bus.o_data), 32'(exp_data(7)));
      chk("bp_ack", 32'(bus.ch_ack), 32'd0);
      tick();
    end
    bus.o_ready = 1'b1;
    #1;
    chk("bp_release_ack", 32'(bus.ch_ack), 32'(bit_of(7)));
    bus.ch_req = '0;
    tick();
    bus.o_ready = 1'b0;
    #1;
    chk("bp_after_ack", 32'(bus.ch_ack), 32'd0);
    chk("bp_after_valid", 32'(bus.o_valid), 32'd0);

    // Channel 28 leaves the pointer at 29, then wrap 29,30,0,29
    do_xfer(28);
    bus.ch_req  = bit_of(0) | bit_of(29) | bit_of(30);
    bus.o_ready = 1'b1;
    tick();
    chk("rr_first_sel", 32'(bus.sel), 32'd29);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_valid", 32'(bus.o_valid), 32'd1);
      chk("rr_ch", 32'(bus.o_ch), 32'(rr_seq[k]));
      chk("rr_data", 32'(bus.o_data), 32'(exp_data(rr_seq[k])));
      chk("rr_ack", 32'(bus.ch_ack), 32'(bit_of(rr_seq[k])));
`ifdef MUX_SCAN_PARITY_EN
      chk("rr_par", 32'(bus.o_par), 32'(^exp_data(rr_seq[k])));
`endif
      if (k == 3) bus.ch_req = '0;
      tick();
      chk("rr_gap_valid", 32'(bus.o_valid), 32'd0);
      chk("rr_gap_ack", 32'(bus.ch_ack), 32'd0);
    end
    chk("rr_end_busy", 32'(busy), 32'd0);

    // Select holds at 12 while idle
    do_xfer(12);
    tick();
    tick();
    chk("hold_sel", 32'(bus.sel), 32'd12);
    chk("hold_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
